// File: rtl/baud_ce_pkg.sv
// Shared defaults and named divisors for the UART baud clock-enable generator.
// Ports: none (package only).
// Divisors assume a 100 MHz core clock and 16x oversampling.
package baud_ce_pkg;

  localparam int CNT_W_DEF   = 16;
  localparam int OVS_DEF     = 16;
  localparam int FRAC_W_DEF  = 4;
  localparam int DIV_RST_DEF = 651;

  // 100 MHz / (baud * 16), rounded to nearest.
  localparam int DIV_9600_100M   = 651;
  localparam int DIV_115200_100M = 54;

endpackage

// File: rtl/ce_prescaler.sv
// Prescaler for baud_ce_gen: counts 0..D-1 and flags the wrap edge; holds the
// divisor shadow register and transfers it only at period boundaries.
// Ports: clk_i/rst_i (sync, active-high), en_i, sync_i, div_we_i, div_in_i,
//   [div_frac_i when BAUD_CE_FRAC_EN], wrap_o (combinational), div_cur_o.
// Macro BAUD_CE_FRAC_EN adds a fractional accumulator that stretches a
// period by one cycle whenever the next accumulate would carry.
module ce_prescaler
  import baud_ce_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
`ifdef BAUD_CE_FRAC_EN
  parameter int FRAC_W  = FRAC_W_DEF,
`endif
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              sync_i,
  input  logic              div_we_i,
  input  logic [CNT_W-1:0]  div_in_i,
`ifdef BAUD_CE_FRAC_EN
  input  logic [FRAC_W-1:0] div_frac_i,
`endif
  output logic              wrap_o,
  output logic [CNT_W-1:0]  div_cur_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             pend_eff;
  logic             wr_ok;
  logic             load;
  logic             wrap;
  logic             ext;
  logic [CNT_W:0]   term;

`ifdef BAUD_CE_FRAC_EN
  logic [FRAC_W-1:0] frac_sh_q, frac_sh_d;
  logic [FRAC_W-1:0] frac_cur_q, frac_cur_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W-1:0] acc_sum;
  // The period about to end is one cycle longer if this wrap's add carries.
  assign {ext, acc_sum} = {1'b0, acc_q} + {1'b0, frac_cur_q};
`else
  assign ext = 1'b0;
`endif

  // A zero divisor would stall the prescaler, so such writes are dropped.
  assign wr_ok    = div_we_i && (div_in_i != '0);
  assign pend_eff = wr_ok || pend_q;

  // Terminal count is D-1 (+1 on a fractional stretch). Using >= keeps the
  // counter from running past terminal if a smaller divisor was loaded
  // while EN was low.
  assign term = {1'b0, div_cur_q} - {{CNT_W{1'b0}}, 1'b1} + {{CNT_W{1'b0}}, ext};
  assign wrap = en_i && !sync_i && ({1'b0, cnt_q} >= term);

  // Safe points to swap divisors: period boundary, stalled, or phase restart.
  assign load = wrap || !en_i || sync_i;

  always_comb begin
    cnt_d = cnt_q;
    if (sync_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
    shadow_d  = wr_ok ? div_in_i : shadow_q;
    pend_d    = pend_eff && !load;
    div_cur_d = (load && pend_eff) ? shadow_d : div_cur_q;
  end

`ifdef BAUD_CE_FRAC_EN
  always_comb begin
    frac_sh_d  = wr_ok ? div_frac_i : frac_sh_q;
    frac_cur_d = (load && pend_eff) ? frac_sh_d : frac_cur_q;
    acc_d      = acc_q;
    if (sync_i) begin
      acc_d = '0;
    end else if (wrap) begin
      acc_d = acc_sum;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frac_sh_q  <= '0;
      frac_cur_q <= '0;
      acc_q      <= '0;
    end else begin
      frac_sh_q  <= frac_sh_d;
      frac_cur_q <= frac_cur_d;
      acc_q      <= acc_d;
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      div_cur_q <= CNT_W'(DIV_RST);
      shadow_q  <= CNT_W'(DIV_RST);
      pend_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_cur_q <= div_cur_d;
      shadow_q  <= shadow_d;
      pend_q    <= pend_d;
    end
  end

  assign wrap_o    = wrap;
  assign div_cur_o = div_cur_q;

endmodule

// File: rtl/baud_ce_gen.sv
// UART baud clock-enable generator: oversample, mid-bit and bit-end strobes.
// Ports: CLK, RST (sync, active-high), EN, SYNC (phase restart), DIV_WE/DIV_IN
//   (divisor update), [DIV_FRAC when BAUD_CE_FRAC_EN], CE_OVS, CE_HALF, CE_BIT,
//   DIV_CUR. All strobes are registered one-cycle pulses. OVS must be even, >= 4.
module baud_ce_gen
  import baud_ce_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int OVS     = OVS_DEF,
`ifdef BAUD_CE_FRAC_EN
  parameter int FRAC_W  = FRAC_W_DEF,
`endif
  parameter int DIV_RST = DIV_RST_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              SYNC,
  input  logic              DIV_WE,
  input  logic [CNT_W-1:0]  DIV_IN,
`ifdef BAUD_CE_FRAC_EN
  input  logic [FRAC_W-1:0] DIV_FRAC,
`endif
  output logic              CE_OVS,
  output logic              CE_HALF,
  output logic              CE_BIT,
  output logic [CNT_W-1:0]  DIV_CUR
);

  localparam int              PH_W    = $clog2(OVS);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVS - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(OVS / 2 - 1);

  logic            wrap;
  logic [PH_W-1:0] phase_q, phase_d;
  logic            ce_ovs_q, ce_ovs_d;
  logic            ce_half_q, ce_half_d;
  logic            ce_bit_q, ce_bit_d;

  ce_prescaler #(
    .CNT_W   (CNT_W),
`ifdef BAUD_CE_FRAC_EN
    .FRAC_W  (FRAC_W),
`endif
    .DIV_RST (DIV_RST)
  ) u_prescaler (
    .clk_i      (CLK),
    .rst_i      (RST),
    .en_i       (EN),
    .sync_i     (SYNC),
    .div_we_i   (DIV_WE),
    .div_in_i   (DIV_IN),
`ifdef BAUD_CE_FRAC_EN
    .div_frac_i (DIV_FRAC),
`endif
    .wrap_o     (wrap),
    .div_cur_o  (DIV_CUR)
  );

  // wrap is already suppressed by SYNC and EN=0, so strobes fall to 0 there.
  always_comb begin
    phase_d   = phase_q;
    ce_ovs_d  = wrap;
    ce_half_d = wrap && (phase_q == PH_HALF);
    ce_bit_d  = wrap && (phase_q == PH_LAST);
    if (SYNC) begin
      phase_d = '0;
    end else if (wrap) begin
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      phase_q   <= '0;
      ce_ovs_q  <= 1'b0;
      ce_half_q <= 1'b0;
      ce_bit_q  <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      ce_ovs_q  <= ce_ovs_d;
      ce_half_q <= ce_half_d;
      ce_bit_q  <= ce_bit_d;
    end
  end

  assign CE_OVS  = ce_ovs_q;
  assign CE_HALF = ce_half_q;
  assign CE_BIT  = ce_bit_q;

endmodule

// File: doc/baud_ce_gen.md
BAUD_CE_GEN -- requirements
Module: baud_ce_gen

Interface
REQ-001 The module SHALL take parameter CNT_W, default 16: prescaler divisor width.
REQ-002 The module SHALL take parameter OVS, default 16: oversample strobes per bit; even, at least 4.
REQ-003 The module SHALL take parameter DIV_RST, default 651: divisor loaded at reset (9600 baud x16 at 100 MHz).
REQ-004 The module SHALL have port CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The module SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port EN, input, 1 bit: count enable.
REQ-007 The module SHALL have port SYNC, input, 1 bit: phase restart, pulsed on start-bit detection.
REQ-008 The module SHALL have port DIV_WE, input, 1 bit: divisor write strobe.
REQ-009 The module SHALL have port DIV_IN, input, CNT_W bits: new divisor.
REQ-010 The module SHALL have port CE_OVS, output, 1 bit: one-cycle oversample strobe.
REQ-011 The module SHALL have port CE_HALF, output, 1 bit: one-cycle mid-bit strobe.
REQ-012 The module SHALL have port CE_BIT, output, 1 bit: one-cycle bit-end strobe.
REQ-013 The module SHALL have port DIV_CUR, output, CNT_W bits: divisor currently in effect.

Function
REQ-014 The prescaler SHALL count 0..D-1 on each edge with EN=1, where D = DIV_CUR; at D-1 it wraps to 0 and CE_OVS is registered high for exactly one cycle.
REQ-015 The phase counter SHALL advance 0..OVS-1 on each CE_OVS event and wrap to 0.
REQ-016 CE_HALF SHALL pulse, coincident with CE_OVS, on the event that takes the phase counter from OVS/2-1 to OVS/2; CE_BIT SHALL pulse on the event that wraps it from OVS-1 to 0.
REQ-017 All strobes SHALL be registered outputs: first CE_OVS is high in the cycle after the D-th enabled edge following reset or SYNC.
REQ-018 With D=1, CE_OVS SHALL stay high on every enabled cycle.
REQ-019 With EN=0, both counters SHALL hold and all strobes SHALL be 0.
REQ-020 SYNC=1 SHALL clear both counters and force all strobes to 0 that edge, regardless of EN; SYNC coinciding with a wrap SHALL win, with no strobe.
REQ-021 DIV_WE=1 with DIV_IN != 0 SHALL store DIV_IN into a shadow register; DIV_IN = 0 SHALL be ignored.
REQ-022 The shadow SHALL transfer to DIV_CUR at the next prescaler wrap, or on the same edge when EN=0 or SYNC=1, so no shortened or runt period occurs.
REQ-023 A second DIV_WE before transfer SHALL overwrite the shadow; the last value wins.

Reset
REQ-024 RST SHALL set the prescaler and phase counter to 0, CE_OVS/CE_HALF/CE_BIT to 0, DIV_CUR and the shadow to DIV_RST, and clear any pending load; RST SHALL override all other inputs.
REQ-025 RST mid-period SHALL discard the partial period; the next CE_OVS follows REQ-017.

Configuration
REQ-026 With macro BAUD_CE_FRAC_EN defined, the module SHALL add parameter FRAC_W (default 4) and input DIV_FRAC[FRAC_W-1:0], shadowed and transferred alongside DIV_IN.
REQ-027 With BAUD_CE_FRAC_EN defined, each prescaler wrap SHALL add DIV_FRAC to an FRAC_W-bit accumulator; a carry SHALL lengthen the next period to D+1; the accumulator SHALL clear on RST and SYNC.
REQ-028 With BAUD_CE_FRAC_EN undefined, DIV_FRAC and the accumulator SHALL be absent and behaviour SHALL be integer-only.

Structure
REQ-029 Package baud_ce_pkg SHALL hold the CNT_W, OVS, FRAC_W and DIV_RST defaults, and named divisor constants for 9600/115200 baud at 100 MHz.
REQ-030 The prescaler, with its shadow, load and fractional logic, SHALL be sub-module ce_prescaler; the phase counter and strobe decode SHALL stay in baud_ce_gen.

Verification
REQ-031 Bench: RST, then EN=1 with D=651 -> CE_OVS at cycles 651, 1302, ...; CE_HALF with the 8th CE_OVS; CE_BIT with the 16th, at cycle 10416.
REQ-032 Bench: DIV_IN=4 via DIV_WE at prescaler count 100 of D=651 -> current period completes at 651; subsequent CE_OVS period is 4; DIV_CUR changes only at the wrap.
REQ-033 Bench: SYNC at phase 5, prescaler 300 -> no strobe that cycle; next CE_OVS 651 cycles later; CE_BIT 16 events later.
REQ-034 Bench: EN low for 50 cycles mid-period -> period stretched by exactly 50 cycles; no strobes while low; DIV_IN=0 write -> DIV_CUR unchanged.
REQ-035 Bench: D=1 -> CE_OVS high on every enabled cycle; CE_BIT every 16 cycles.
REQ-036 Bench, BAUD_CE_FRAC_EN defined, D=10, DIV_FRAC=8, FRAC_W=4 -> periods alternate 10,11; 32 CE_OVS events span 336 cycles.
